uart_telemetry_fsm: RTL and testbench

Multi-field telemetry formatter. It pops one packed record per frame from the telemetry FIFO and streams it as an ASCII line over the UART byte transmitter. Each line is an optional sequence prefix, then NUM_FIELDS hex fields joined by a separator, then a line terminator. Runtime modes select CRLF or LF-only termination and leading-zero suppression. It sits between the PID data FIFO and uart_tx.

---
 rtl/uart_fmt_pkg.sv | 23 ++
 rtl/uart_byte_sender.sv | 62 ++++++
 rtl/uart_telemetry_fsm.sv | 154 +++++++++++++++
 tb/tb_uart_telemetry_fsm.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_fmt_pkg.sv
// Shared types and ASCII helpers for the telemetry line formatter.
package uart_fmt_pkg;

   typedef enum logic [3:0] {
      ST_IDLE, ST_READ, ST_SEQ_HI, ST_SEQ_LO, ST_COLON,
      ST_DIGIT, ST_SEP, ST_CR, ST_LF
   } fsm_state_e;

   typedef enum logic [1:0] {
      TX_IDLE, TX_SEND, TX_WAIT
   } tx_state_e;

   localparam logic [7:0] CHR_CR    = 8'h0D;
   localparam logic [7:0] CHR_LF    = 8'h0A;
   localparam logic [7:0] CHR_COLON = 8'h3A;

   // Uppercase hex digit.
   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
      if (n < 4'd10) return 8'h30 + {4'h0, n};
      else           return 8'h37 + {4'h0, n};
   endfunction

endpackage

// File: rtl/uart_byte_sender.sv
// One-byte SEND/WAIT handshake with the UART: a single start pulse,
// then wait for done. Done is only honoured in WAIT.
module uart_byte_sender
   import uart_fmt_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clr,
   input  logic       load,
   input  logic [7:0] load_byte,
   input  logic       uart_tx_done,
   output logic       uart_start_tx,
   output logic [7:0] uart_tx_din,
   output logic       byte_done
);

   tx_state_e  st_q, st_d;
   logic       start_q, start_d;
   logic [7:0] din_q, din_d;

   always_comb begin
      st_d      = st_q;
      start_d   = 1'b0;
      din_d     = din_q;
      byte_done = 1'b0;
      case (st_q)
         TX_IDLE: if (load) begin
            start_d = 1'b1;
            din_d   = load_byte;
            st_d    = TX_SEND;
         end
         TX_SEND: st_d = TX_WAIT;
         TX_WAIT: if (uart_tx_done) begin
            byte_done = 1'b1;
            st_d      = TX_IDLE;
         end
         default: st_d = TX_IDLE;
      endcase
      if (clr) begin
         st_d      = TX_IDLE;
         start_d   = 1'b0;
         din_d     = 8'h00;
         byte_done = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         st_q    <= TX_IDLE;
         start_q <= 1'b0;
         din_q   <= 8'h00;
      end else begin
         st_q    <= st_d;
         start_q <= start_d;
         din_q   <= din_d;
      end
   end

   assign uart_start_tx = start_q;
   assign uart_tx_din   = din_q;

endmodule

// File: rtl/uart_telemetry_fsm.sv
// Pops one FIFO record per frame and streams it as an ASCII hex line:
// optional "NN:" prefix, separator-joined fields, CR LF or LF.
module uart_telemetry_fsm
   import uart_fmt_pkg::*;
#(
   parameter int         FIELD_WIDTH = 32,
   parameter int         NUM_FIELDS  = 3,
   parameter logic [7:0] SEP_CHAR    = 8'h2C,
   parameter bit         SEQ_EN      = 1'b1
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                fsm_en,
   input  logic                                mode_crlf,
   input  logic                                mode_zs,
   input  logic                                uart_tx_done,
   output logic                                uart_start_tx,
   output logic [7:0]                          uart_tx_din,
   input  logic [NUM_FIELDS*FIELD_WIDTH-1:0]   fifo_rd_data,
   input  logic                                fifo_empty,
   output logic                                fifo_rd_en,
   output logic                                busy,
   output logic [7:0]                          seq_num
);

   localparam int NDIG  = FIELD_WIDTH / 4;
   localparam int REC_W = NUM_FIELDS * FIELD_WIDTH;
   localparam int DIG_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int FLD_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

   fsm_state_e       state_q;
   logic [REC_W-1:0] rec_q;
   logic             crlf_q, zs_q, nz_q, sent_q, send_q;
   logic [7:0]       byte_q, seq_q;
   logic [DIG_W-1:0] digit_q;
   logic [FLD_W-1:0] field_q;

   logic             byte_done, last_dig, last_fld, skip;
   logic [3:0]       nib;
   logic [7:0]       emit_byte;
   fsm_state_e       nxt_state;

   // The record shifts left one nibble per digit, so the current nibble
   // is always at the top and the next field follows on naturally.
   assign nib      = rec_q[REC_W-1 -: 4];
   assign last_dig = (digit_q == DIG_W'(NDIG - 1));
   assign last_fld = (field_q == FLD_W'(NUM_FIELDS - 1));
   assign skip     = (state_q == ST_DIGIT) && zs_q && !nz_q && (nib == 4'h0) && !last_dig;

   always_comb begin
      emit_byte = 8'h00;
      nxt_state = ST_IDLE;
      case (state_q)
         ST_SEQ_HI: begin emit_byte = nibble_to_ascii(seq_q[7:4]); nxt_state = ST_SEQ_LO; end
         ST_SEQ_LO: begin emit_byte = nibble_to_ascii(seq_q[3:0]); nxt_state = ST_COLON;  end
         ST_COLON:  begin emit_byte = CHR_COLON;                   nxt_state = ST_DIGIT;  end
         ST_DIGIT: begin
            emit_byte = nibble_to_ascii(nib);
            if (!last_dig)     nxt_state = ST_DIGIT;
            else if (!last_fld) nxt_state = ST_SEP;
            else               nxt_state = crlf_q ? ST_CR : ST_LF;
         end
         ST_SEP:    begin emit_byte = SEP_CHAR; nxt_state = ST_DIGIT; end
         ST_CR:     begin emit_byte = CHR_CR;   nxt_state = ST_LF;    end
         ST_LF:     begin emit_byte = CHR_LF;   nxt_state = ST_IDLE;  end
         default:   ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         rec_q   <= '0;
         crlf_q  <= 1'b0;
         zs_q    <= 1'b0;
         nz_q    <= 1'b0;
         sent_q  <= 1'b0;
         send_q  <= 1'b0;
         byte_q  <= 8'h00;
         seq_q   <= 8'h00;
         digit_q <= '0;
         field_q <= '0;
      end else if (!fsm_en) begin
         state_q <= ST_IDLE;
         sent_q  <= 1'b0;
         send_q  <= 1'b0;
         byte_q  <= 8'h00;
         nz_q    <= 1'b0;
         digit_q <= '0;
         field_q <= '0;
      end else begin
         send_q <= 1'b0;
         case (state_q)
            ST_IDLE: if (!fifo_empty) state_q <= ST_READ;
            ST_READ: begin
               rec_q   <= fifo_rd_data;
               crlf_q  <= mode_crlf;
               zs_q    <= mode_zs;
               nz_q    <= 1'b0;
               sent_q  <= 1'b0;
               digit_q <= '0;
               field_q <= '0;
               state_q <= SEQ_EN ? ST_SEQ_HI : ST_DIGIT;
            end
            default: begin
               if (!sent_q) begin
                  if (skip) begin
                     rec_q   <= rec_q << 4;
                     digit_q <= digit_q + DIG_W'(1);
                  end else begin
                     send_q <= 1'b1;
                     byte_q <= emit_byte;
                     sent_q <= 1'b1;
                     if (state_q == ST_DIGIT) begin
                        rec_q <= rec_q << 4;
                        nz_q  <= 1'b1;
                     end
                  end
               end else if (byte_done) begin
                  sent_q  <= 1'b0;
                  state_q <= nxt_state;
                  if (state_q == ST_DIGIT) begin
                     if (!last_dig) digit_q <= digit_q + DIG_W'(1);
                     else begin
                        digit_q <= '0;
                        nz_q    <= 1'b0;
                        if (!last_fld) field_q <= field_q + FLD_W'(1);
                     end
                  end
                  if (state_q == ST_LF) seq_q <= seq_q + 8'd1;
               end
            end
         endcase
      end
   end

   uart_byte_sender u_sender (
      .clk          (clk),
      .reset_n      (reset_n),
      .clr          (!fsm_en),
      .load         (send_q),
      .load_byte    (byte_q),
      .uart_tx_done (uart_tx_done),
      .uart_start_tx(uart_start_tx),
      .uart_tx_din  (uart_tx_din),
      .byte_done    (byte_done)
   );

   // Pop is issued from IDLE so the record is on fifo_rd_data in READ.
   assign fifo_rd_en = reset_n && fsm_en && (state_q == ST_IDLE) && !fifo_empty;
   assign busy       = (state_q != ST_IDLE);
   assign seq_num    = seq_q;

endmodule

// File: tb/tb_uart_telemetry_fsm.sv
// Directed bench for uart_telemetry_fsm: table of frames plus abort,
// wrap and back-to-back sequences.
module tb_uart_telemetry_fsm;

   logic        clk = 1'b0;
   logic        reset_n, fsm_en, mode_crlf, mode_zs;
   logic        uart_tx_done, uart_start_tx, fifo_rd_en, busy, fifo_empty;
   logic [7:0]  uart_tx_din, seq_num;
   logic [95:0] fifo_rd_data = '0;

   logic        resp_done = 1'b0, idle_spur = 1'b0, spur_en = 1'b0, mon_en = 1'b0;
   logic        prev_busy = 1'b0;
   int          pushed = 0, popped = 0, gap_err = 0;
   int          nchk = 0, nerr = 0;
   string       line = "";
   logic [95:0] fifo_q[$];

   always #5 clk = ~clk;

   assign uart_tx_done = resp_done | idle_spur;
   assign fifo_empty   = (pushed == popped);

   uart_telemetry_fsm dut (
      .clk(clk), .reset_n(reset_n), .fsm_en(fsm_en), .mode_crlf(mode_crlf),
      .mode_zs(mode_zs), .uart_tx_done(uart_tx_done), .uart_start_tx(uart_start_tx),
      .uart_tx_din(uart_tx_din), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en), .busy(busy), .seq_num(seq_num)
   );

   // FIFO model with one-cycle read latency.
   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_rd_data <= fifo_q.pop_front();
         popped       <= popped + 1;
      end
   end

   // UART model: log each started byte, optionally pulse done in the SEND cycle.
   always begin
      @(negedge clk);
      if (uart_start_tx) begin
         line = $sformatf("%s%c", line, uart_tx_din);
         resp_done = spur_en;
         @(negedge clk); resp_done = 1'b0;
         @(negedge clk); resp_done = 1'b1;
         @(negedge clk); resp_done = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (prev_busy && !busy && (pushed != popped) && !fifo_rd_en) gap_err++;
         if (fifo_rd_en && busy) gap_err++;
      end
      prev_busy = busy;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_s(input string name, input string act, input string exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got len %0d \"%s\" expected len %0d \"%s\"", name, act.len(), act, exp.len(), exp);
      end
   endtask

   task automatic push_rec(input logic [95:0] r);
      fifo_q.push_back(r);
      pushed = pushed + 1;
   endtask

   task automatic run_frame(input string name, input logic [95:0] rec, input bit zs, input bit crlf,
                            input bit push, input bit tog, input bit spur,
                            input string exp, input logic [7:0] eseq);
      int   p0;
      logic [7:0] s0;
      bit   done;
      mode_zs = zs; mode_crlf = crlf; spur_en = spur;
      line = ""; p0 = popped; s0 = seq_num; done = 0;
      if (push) push_rec(rec);
      for (int c = 0; c < 3000 && !done; c++) begin
         @(negedge clk);
         if (tog && line.len() == 5) mode_crlf = !crlf;
         if (seq_num != s0 && !busy) done = 1;
      end
      spur_en = 1'b0;
      chk({name, "_timeout"}, 32'(done), 32'd1);
      chk_s({name, "_bytes"}, line, exp);
      chk({name, "_seq"}, 32'(seq_num), 32'(eseq));
      chk({name, "_pops"}, 32'(popped - p0), 32'd1);
   endtask

   typedef struct {
      logic [95:0] rec;
      bit          zs, crlf, push, tog, spur;
      logic [7:0]  seq;
   } vec_t;

   vec_t  vt[4];
   string vexp[4];

   initial begin
      logic [95:0] rec0;
      bit          hit;
      rec0 = {32'h0000_00AB, 32'hDEAD_BEEF, 32'h0000_0001};
      vt[0] = '{rec0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01};
      vexp[0] = "00:000000AB,DEADBEEF,00000001\r\n";
      vt[1] = '{rec0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h02};
      vexp[1] = "01:AB,DEADBEEF,1\n";
      vt[2] = '{{32'h0, 32'h00F0_0000, 32'h0000_0010}, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h03};
      vexp[2] = "02:0,F00000,10\r\n";
      vt[3] = '{{32'hFFFF_FFFF, 32'h0, 32'h0000_000A}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h04};
      vexp[3] = "03:FFFFFFFF,00000000,0000000A\n";

      reset_n = 1'b0; fsm_en = 1'b1; mode_zs = 1'b0; mode_crlf = 1'b1;
      push_rec(rec0);
      repeat (3) @(negedge clk);
      chk("rst_start", 32'(uart_start_tx), 32'd0);
      chk("rst_din",   32'(uart_tx_din),   32'd0);
      chk("rst_rd_en", 32'(fifo_rd_en),    32'd0);
      chk("rst_busy",  32'(busy),          32'd0);
      chk("rst_seq",   32'(seq_num),       32'd0);

      reset_n = 1'b1; fsm_en = 1'b0;
      repeat (4) @(negedge clk);
      chk("dis_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("dis_pops",  32'(popped),     32'd0);
      chk("dis_busy",  32'(busy),       32'd0);

      fsm_en = 1'b1;
      for (int i = 0; i < 4; i++)
         run_frame($sformatf("vec%0d", i), vt[i].rec, vt[i].zs, vt[i].crlf, vt[i].push,
                   vt[i].tog, vt[i].spur, vexp[i], vt[i].seq);

      // Spurious done while idle.
      line = "";
      idle_spur = 1'b1; @(negedge clk); idle_spur = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_spur_bytes", 32'(line.len()), 32'd0);
      chk("idle_spur_busy",  32'(busy),       32'd0);

      // Abort mid-field for one cycle, then a fresh line.
      mode_zs = 1'b0; mode_crlf = 1'b1; line = ""; hit = 0;
      push_rec(rec0);
      for (int c = 0; c < 500 && !hit; c++) begin
         @(negedge clk);
         if (line.len() >= 6) hit = 1;
      end
      chk("abort_reach", 32'(hit), 32'd1);
      fsm_en = 1'b0;
      @(negedge clk);
      chk("abort_busy",  32'(busy),          32'd0);
      chk("abort_start", 32'(uart_start_tx), 32'd0);
      chk("abort_seq",   32'(seq_num),       32'h04);
      fsm_en = 1'b1;
      run_frame("fresh", rec0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                "04:000000AB,DEADBEEF,00000001\r\n", 8'h05);

      // Back-to-back frames up to seq 0xFF.
      begin
         int p0;
         mode_zs = 1'b1; mode_crlf = 1'b0; line = ""; hit = 0;
         p0 = popped;
         for (int i = 0; i < 250; i++) push_rec('0);
         mon_en = 1'b1;
         for (int c = 0; c < 20000 && !hit; c++) begin
            @(negedge clk);
            if (seq_num == 8'hFF && !busy) hit = 1;
         end
         mon_en = 1'b0;
         chk("bulk_seq",  32'(seq_num),      32'hFF);
         chk("bulk_pops", 32'(popped - p0),  32'd250);
         chk("bulk_gaps", 32'(gap_err),      32'd0);
      end

      run_frame("wrap", {32'h0, 32'h0000_1234, 32'h0}, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                "FF:0,1234,0\r\n", 8'h00);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
